fifo_ctrl16x8: RTL and testbench
================================

FIFO_CTRL16X8 -- requirements
Module: fifo_ctrl16x8

Interface
REQ-001 The block SHALL use parameter WIDTH, default 8, as the data width, matching ram16x8 wr_data/dout.
REQ-002 The block SHALL use parameter AW, default 4, as the address width; depth is 2**AW (16).
REQ-003 The block SHALL have these ports, one per line:
- clock  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- push  in  1  write request.
- push_data  in  WIDTH  write data.
- pop  in  1  read request.
- full  out  1  no free slot.
- empty  out  1  no stored entry.
- count  out  AW+1  occupancy, 0..16.
- ram_wr_data  out  WIDTH  to ram16x8 wr_data.
- ram_wen  out  1  to ram16x8 wen.
- ram_w_addr  out  AW  to ram16x8 w_addr.
- ram_ren  out  1  to ram16x8 ren.
- ram_r_addr  out  AW  to ram16x8 r_addr.
- ram_dout  in  WIDTH  from ram16x8 dout.
- pop_data  out  WIDTH  read data.
- pop_valid  out  1  pop_data valid this cycle.

Function
REQ-004 The block SHALL accept push only when full=0 (push_acc) and pop only when empty=0 (pop_acc).
REQ-005 ram_wen, ram_w_addr and ram_wr_data SHALL be combinational: ram_wen=push_acc, ram_w_addr=wr_ptr, ram_wr_data=push_data.
REQ-006 ram_ren, ram_r_addr SHALL be combinational: ram_ren=pop_acc, ram_r_addr=rd_ptr.
REQ-007 wr_ptr SHALL increment on push_acc and rd_ptr on pop_acc, modulo 16 (15 wraps to 0).
REQ-008 count SHALL become count+1 on push_acc only, count-1 on pop_acc only, and stay unchanged on both or neither.
REQ-009 full SHALL equal (count==16) and empty SHALL equal (count==0), both derived from registered count.
REQ-010 When full, push+pop in one cycle SHALL accept the pop and reject the push.
REQ-011 When empty, push+pop in one cycle SHALL accept the push and reject the pop; there is no bypass.
REQ-012 pop_valid SHALL be a register set to pop_acc, so it is high exactly one cycle after each accepted pop.
REQ-013 pop_data SHALL equal ram_dout while pop_valid=1; it is undefined otherwise.
REQ-014 Data SHALL leave in write order, with latency of 1 cycle from pop_acc to pop_valid.
REQ-015 Control SHALL be a 3-state FSM with states EMPTY (count 0), PART (1..15) and FULL (16), updated per REQ-008:
- EMPTY->PART on push_acc.
- PART->FULL on a push-only that reaches 16.
- PART->EMPTY on a pop-only that reaches 0.
- FULL->PART on pop_acc.

Reset
REQ-016 On rst=0 the block SHALL asynchronously clear wr_ptr, rd_ptr, count and pop_valid, and set state to EMPTY.
REQ-017 While rst=0, outputs SHALL be: empty=1, full=0, count=0, ram_wen=0, ram_ren=0, pop_valid=0.
REQ-018 Reset mid-operation SHALL discard all stored entries; RAM contents are not cleared.
REQ-019 Deassertion of rst SHALL be synchronised by the integrator; the first push is honoured on the first rising edge with rst=1.

Configuration
REQ-020 With FIFO_CTRL_ERR_EN defined, the block SHALL add outputs overflow_err and underflow_err, each 1 bit.
- overflow_err is sticky and set on push while full.
- underflow_err is sticky and set on pop while empty.
- Both are cleared only by reset.
REQ-021 Without FIFO_CTRL_ERR_EN, those ports and their registers SHALL NOT exist; rejected requests are silently dropped.

Structure
REQ-022 A shared package fifo_pkg SHALL hold the WIDTH/AW defaults, the DEPTH constant (16) and the state typedef {EMPTY, PART, FULL}.
REQ-023 The block SHALL contain no RAM; the natural top wrapper is fifo16x8, which instantiates fifo_ctrl16x8 plus ram16x8.

Verification
REQ-024 Bench (fifo16x8 wrapper) SHALL cover:
- Reset, then push 0xA5 -> count=1, empty=0; pop -> pop_valid next cycle with pop_data=0xA5, count=0, empty=1.
- Push 0x00..0x0F -> full=1, count=16; push 0xFF -> ignored (overflow_err=1 if enabled); pop 16 times -> 0x00..0x0F in order, then empty=1.
- Wrap: push 20, pop 20 interleaved -> rd_ptr/wr_ptr wrap past 15, data order preserved, count=0.
- Full + push 0x77 + pop in the same cycle -> oldest entry popped, 0x77 not stored, count=15.
- Empty + push 0x3C + pop in the same cycle -> pop ignored, pop_valid=0 next cycle, count=1, then pop returns 0x3C.
- rst=0 at count=7 -> immediately count=0, empty=1, pop_valid=0; next push 0x11 then pop returns 0x11.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and control-state encoding for the 16x8 FIFO controller and its wrapper.
package fifo_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int AW_DEF    = 4;
    localparam int DEPTH     = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PART  = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_ctrl16x8.sv
// Pointer/occupancy controller for a 16-entry FIFO driving an external ram16x8 (no storage here).
// Define FIFO_CTRL_ERR_EN to add sticky overflow_err/underflow_err outputs.
module fifo_ctrl16x8
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic [WIDTH-1:0] ram_wr_data,
    output logic             ram_wen,
    output logic [AW-1:0]    ram_w_addr,
    output logic             ram_ren,
    output logic [AW-1:0]    ram_r_addr,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid
`ifdef FIFO_CTRL_ERR_EN
    ,
    output logic             overflow_err,
    output logic             underflow_err
`endif
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(2**AW);
    localparam logic [AW:0] LAST_SLOT  = (AW+1)'(2**AW - 1);
    localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_acc;
    logic          pop_acc;
    state_t        state;
    state_t        state_next;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Gating with rst keeps the RAM strobes quiet while reset is held.
    assign push_acc = push & ~full  & rst;
    assign pop_acc  = pop  & ~empty & rst;

    assign ram_wen     = push_acc;
    assign ram_w_addr  = wr_ptr;
    assign ram_wr_data = push_data;
    assign ram_ren     = pop_acc;
    assign ram_r_addr  = rd_ptr;
    assign pop_data    = ram_dout;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
            state     <= EMPTY;
        end else begin
            if (push_acc)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_acc)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_acc && !pop_acc)
                count <= count + ONE_COUNT;
            else if (pop_acc && !push_acc)
                count <= count - ONE_COUNT;
            pop_valid <= pop_acc;
            state     <= state_next;
        end
    end

    // Simultaneous push+pop leaves occupancy unchanged, so only one-sided moves change state.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (push_acc) state_next = PART;
            PART: begin
                if (push_acc && !pop_acc && count == LAST_SLOT)
                    state_next = FULL;
                else if (pop_acc && !push_acc && count == ONE_COUNT)
                    state_next = EMPTY;
            end
            FULL: if (pop_acc) state_next = PART;
            default: state_next = EMPTY;
        endcase
    end

`ifdef FIFO_CTRL_ERR_EN
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (push && full)
                overflow_err <= 1'b1;
            if (pop && empty)
                underflow_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ctrl16x8.sv
// Directed self-checking bench for fifo_ctrl16x8 with a behavioural ram16x8 model attached.
module tb_fifo_ctrl16x8;

    logic       clock;
    logic       rst;
    logic       push;
    logic [7:0] push_data;
    logic       pop;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic [7:0] ram_wr_data;
    logic       ram_wen;
    logic [3:0] ram_w_addr;
    logic       ram_ren;
    logic [3:0] ram_r_addr;
    logic [7:0] ram_dout;
    logic [7:0] pop_data;
    logic       pop_valid;
`ifdef FIFO_CTRL_ERR_EN
    logic       overflow_err;
    logic       underflow_err;
`endif

    logic [7:0] mem [16];
    int passCount;
    int checkCount;

    fifo_ctrl16x8 dut (
        .clock       (clock),
        .rst         (rst),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .ram_wr_data (ram_wr_data),
        .ram_wen     (ram_wen),
        .ram_w_addr  (ram_w_addr),
        .ram_ren     (ram_ren),
        .ram_r_addr  (ram_r_addr),
        .ram_dout    (ram_dout),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid)
`ifdef FIFO_CTRL_ERR_EN
        ,
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read RAM: dout updates on the same edge the pop is accepted.
    always @(posedge clock) begin
        if (ram_wen)
            mem[ram_w_addr] <= ram_wr_data;
        if (ram_ren)
            ram_dout <= mem[ram_r_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    endtask

    // Drives one cycle of requests, then returns 1 time unit after the edge so outputs have settled.
    task automatic applyStimulus(input logic doPush, input logic [7:0] data, input logic doPop);
        push      = doPush;
        push_data = data;
        pop       = doPop;
        @(posedge clock);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        rst        = 1'b0;
        push       = 1'b1;
        push_data  = 8'h99;
        pop        = 1'b0;
        ram_dout   = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_wen", 32'(ram_wen), 32'd0);
        checkOutput("rst_pop_valid", 32'(pop_valid), 32'd0);
        push = 1'b0;
        rst  = 1'b1;

        applyStimulus(1'b1, 8'hA5, 1'b0);
        checkOutput("a5_count", 32'(count), 32'd1);
        checkOutput("a5_empty", 32'(empty), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("a5_valid", 32'(pop_valid), 32'd1);
        checkOutput("a5_data", 32'(pop_data), 32'hA5);
        checkOutput("a5_count0", 32'(count), 32'd0);
        checkOutput("a5_empty1", 32'(empty), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("a5_valid_drop", 32'(pop_valid), 32'd0);

        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_count", 32'(count), 32'd16);
        push = 1'b1;
        push_data = 8'hFF;
        #1;
        checkOutput("ovf_wen", 32'(ram_wen), 32'd0);
        applyStimulus(1'b1, 8'hFF, 1'b0);
        checkOutput("ovf_count", 32'(count), 32'd16);
`ifdef FIFO_CTRL_ERR_EN
        checkOutput("ovf_err", 32'(overflow_err), 32'd1);
`endif
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("drain_valid", 32'(pop_valid), 32'd1);
            checkOutput("drain_data", 32'(pop_data), 32'(i));
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);

        applyStimulus(1'b1, 8'h40, 1'b0);
        for (int k = 1; k < 20; k++) begin
            applyStimulus(1'b1, 8'(8'h40 + k), 1'b1);
            checkOutput("wrap_data", 32'(pop_data), 32'(8'h40 + k - 1));
            checkOutput("wrap_count", 32'(count), 32'd1);
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("wrap_last", 32'(pop_data), 32'h53);
        checkOutput("wrap_count0", 32'(count), 32'd0);

        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0);
        push = 1'b1;
        push_data = 8'h77;
        pop = 1'b1;
        #1;
        checkOutput("fullpp_wen", 32'(ram_wen), 32'd0);
        checkOutput("fullpp_ren", 32'(ram_ren), 32'd1);
        applyStimulus(1'b1, 8'h77, 1'b1);
        checkOutput("fullpp_data", 32'(pop_data), 32'h80);
        checkOutput("fullpp_count", 32'(count), 32'd15);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("fullpp_drain", 32'(pop_data), 32'(8'h80 + i));
        end
        checkOutput("fullpp_empty", 32'(empty), 32'd1);

        push = 1'b1;
        push_data = 8'h3C;
        pop = 1'b1;
        #1;
        checkOutput("emptypp_ren", 32'(ram_ren), 32'd0);
        applyStimulus(1'b1, 8'h3C, 1'b1);
        checkOutput("emptypp_valid", 32'(pop_valid), 32'd0);
        checkOutput("emptypp_count", 32'(count), 32'd1);
`ifdef FIFO_CTRL_ERR_EN
        checkOutput("udf_err", 32'(underflow_err), 32'd1);
`endif
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("emptypp_data", 32'(pop_data), 32'h3C);
        checkOutput("emptypp_valid1", 32'(pop_valid), 32'd1);

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("mid_count7", 32'(count), 32'd7);
        checkOutput("mid_valid_pre", 32'(pop_valid), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_count", 32'(count), 32'd0);
        checkOutput("mid_rst_empty", 32'(empty), 32'd1);
        checkOutput("mid_rst_valid", 32'(pop_valid), 32'd0);
        @(posedge clock);
        #1;
        rst = 1'b1;
        applyStimulus(1'b1, 8'h11, 1'b0);
        checkOutput("post_rst_count", 32'(count), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("post_rst_data", 32'(pop_data), 32'h11);
        checkOutput("post_rst_empty", 32'(empty), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
